pll_lock_sequencer: RTL and testbench

//  Sequences bring-up of the nano20k rPLL from the 27 MHz board clock (clkin domain).
//  - Drives the PLL RESET pin and waits for LOCK, with a timeout and bounded retries.
//  - Requires LOCK to stay stable before releasing sys_reset_o to the system clock domain.
//  - Detects and counts lock loss, then re-runs the sequence.

---
 rtl/pll_seq_pkg.sv | 27 ++
 rtl/pll_lock_sequencer_sync_2ff.sv | 27 ++
 rtl/pll_lock_sequencer.sv | 154 +++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg
//   Shared definitions for the rPLL lock sequencer:
//   - state_t      : sequencer state encoding (values 5-7 are illegal)
//   - DEF_*        : default timing constants for a 27 MHz reference clock
//   - max3()       : helper used to size the shared timer
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  localparam int DEF_RST_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT  = 27000;  // 1 ms at 27 MHz
  localparam int DEF_STABLE_CYCLES = 2700;   // 100 us at 27 MHz
  localparam int DEF_MAX_RETRIES   = 3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// sync_2ff
//   Two-flop synchronizer for a single asynchronous level signal.
// Ports:
//   clk   in  destination clock
//   rst   in  asynchronous active-high reset (output clears to 0)
//   d     in  asynchronous input
//   q     out synchronized copy of d, two clk edges of latency
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
//   Brings up the rPLL from the board reference clock: pulses the PLL RESET pin,
//   waits (with timeout and bounded retries) for LOCK, demands LOCK stay high for
//   a stable window, then releases the system reset. Lock loss in RUN is counted
//   and the sequence is re-run.
// Ports:
//   clk              in  reference clock (never the PLL output)
//   rst              in  asynchronous active-high reset
//   pll_lock_i       in  rPLL LOCK, asynchronous to clk
//   restart_i        in  synchronous pulse: restart from PLL_RST, clear fault/retries
//   pll_reset_o      out rPLL RESET, active-high
//   sys_reset_o      out system reset request, active-high (low only in RUN)
//   ready_o          out high only in RUN
//   fault_o          out high only in FAULT
//   state_o          out current state encoding
//   retry_cnt_o      out failed attempts since last RUN/restart
//   lock_loss_cnt_o  out lock losses seen in RUN, saturating at 255
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int MAX_RETRIES   = DEF_MAX_RETRIES
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               pll_lock_i,
  input  logic                               restart_i,
  output logic                               pll_reset_o,
  output logic                               sys_reset_o,
  output logic                               ready_o,
  output logic                               fault_o,
  output logic [2:0]                         state_o,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt_o,
  output logic [7:0]                         lock_loss_cnt_o
);

  localparam int TMAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int RW   = $clog2(MAX_RETRIES + 1);

  logic lock_s;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_lock_i),
    .q   (lock_s)
  );

  state_t          state, state_next;
  logic [TW-1:0]   timer, timer_next;
  logic [RW-1:0]   retry, retry_next;
  logic [7:0]      loss,  loss_next;
  logic            fail;
  logic            lost;

  always_comb begin
    state_next = state;
    timer_next = timer;
    retry_next = retry;
    loss_next  = loss;
    fail       = 1'b0;

    // Lock loss in RUN is counted even when a restart wins the transition.
    lost = (state == ST_RUN) && !lock_s;
    if (lost && (loss != 8'hFF)) begin
      loss_next = loss + 8'd1;
    end

    if (restart_i) begin
      state_next = ST_PLL_RST;
      retry_next = '0;
    end else begin
      case (state)
        ST_PLL_RST: begin
          if (timer == TW'(RST_CYCLES - 1)) begin
            state_next = ST_WAIT_LOCK;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_next = ST_STABLE;
          end else if (timer == TW'(LOCK_TIMEOUT - 1)) begin
            fail = 1'b1;
          end
        end
        ST_STABLE: begin
          if (!lock_s) begin
            fail = 1'b1;
          end else if (timer == TW'(STABLE_CYCLES - 1)) begin
            state_next = ST_RUN;
            retry_next = '0;
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_next = ST_PLL_RST;
          end
        end
        ST_FAULT: begin
          state_next = ST_FAULT;
        end
        default: begin
          // Unused encodings fall back to the start of the sequence.
          state_next = ST_PLL_RST;
        end
      endcase

      if (fail) begin
        retry_next = retry + RW'(1);
        state_next = (retry_next == RW'(MAX_RETRIES)) ? ST_FAULT : ST_PLL_RST;
      end
    end

    // Timer restarts on every state entry, including a restart into PLL_RST
    // from PLL_RST. It is frozen in RUN/FAULT so it can never wrap.
    if (restart_i || (state_next != state)) begin
      timer_next = '0;
    end else if ((state == ST_PLL_RST) || (state == ST_WAIT_LOCK) ||
                 (state == ST_STABLE)) begin
      timer_next = timer + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_PLL_RST;
      timer       <= '0;
      retry       <= '0;
      loss        <= '0;
      pll_reset_o <= 1'b1;
      sys_reset_o <= 1'b1;
      ready_o     <= 1'b0;
      fault_o     <= 1'b0;
    end else begin
      state       <= state_next;
      timer       <= timer_next;
      retry       <= retry_next;
      loss        <= loss_next;
      // Outputs decode the next state so they change on the transition edge.
      pll_reset_o <= (state_next == ST_PLL_RST) || (state_next == ST_FAULT);
      sys_reset_o <= (state_next != ST_RUN);
      ready_o     <= (state_next == ST_RUN);
      fault_o     <= (state_next == ST_FAULT);
    end
  end

  assign state_o         = state;
  assign retry_cnt_o     = retry;
  assign lock_loss_cnt_o = loss;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer with short timing parameters.
module tb_pll_lock_sequencer;

  localparam int RST_C = 4;
  localparam int TO_C  = 20;
  localparam int ST_C  = 8;
  localparam int MR_C  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_lock_i = 1'b0;
  logic       restart_i = 1'b0;
  logic       pll_reset_o, sys_reset_o, ready_o, fault_o;
  logic [2:0] state_o;
  logic [1:0] retry_cnt_o;
  logic [7:0] lock_loss_cnt_o;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  pll_lock_sequencer #(
    .RST_CYCLES    (RST_C),
    .LOCK_TIMEOUT  (TO_C),
    .STABLE_CYCLES (ST_C),
    .MAX_RETRIES   (MR_C)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pll_lock_i      (pll_lock_i),
    .restart_i       (restart_i),
    .pll_reset_o     (pll_reset_o),
    .sys_reset_o     (sys_reset_o),
    .ready_o         (ready_o),
    .fault_o         (fault_o),
    .state_o         (state_o),
    .retry_cnt_o     (retry_cnt_o),
    .lock_loss_cnt_o (lock_loss_cnt_o)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Phase numbers: 0 reset pulse, 1 waiting for lock, 2 stability window,
  // 3 running, 4 fault. m_age = edges spent in the current phase.
  int   m_ph, m_age, m_retry, m_loss;
  logic m_s1, m_s2;

  always @(posedge clk or posedge rst) begin : model
    int   ph, ag, rt, ls;
    logic seen, failed;
    if (rst) begin
      m_ph <= 0; m_age <= 0; m_retry <= 0; m_loss <= 0;
      m_s1 <= 1'b0; m_s2 <= 1'b0;
    end else begin
      seen   = m_s2;
      ph     = m_ph;
      ag     = m_age + 1;
      rt     = m_retry;
      ls     = m_loss;
      failed = 1'b0;
      if (ph == 3 && !seen) ls = (ls == 255) ? 255 : ls + 1;
      if (restart_i) begin
        ph = 0; ag = 0; rt = 0;
      end else begin
        case (ph)
          0: if (ag == RST_C) begin ph = 1; ag = 0; end
          1: if (seen) begin ph = 2; ag = 0; end
             else if (ag == TO_C) failed = 1'b1;
          2: if (!seen) failed = 1'b1;
             else if (ag == ST_C) begin ph = 3; ag = 0; rt = 0; end
          3: if (!seen) begin ph = 0; ag = 0; end
          default: ;
        endcase
      end
      if (failed) begin
        rt = rt + 1;
        ph = (rt == MR_C) ? 4 : 0;
        ag = 0;
      end
      m_ph    <= ph;
      m_age   <= ag;
      m_retry <= rt;
      m_loss  <= ls;
      m_s2    <= m_s1;
      m_s1    <= pll_lock_i;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [16:0] exp_v, act_v;
    if (cmp_en) begin
      exp_v = {(m_ph == 0 || m_ph == 4), (m_ph != 3), (m_ph == 3), (m_ph == 4),
               3'(m_ph), 2'(m_retry), 8'(m_loss)};
      act_v = {pll_reset_o, sys_reset_o, ready_o, fault_o, state_o,
               retry_cnt_o, lock_loss_cnt_o};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL cycle_model t=%0t got prst=%b srst=%b rdy=%b flt=%b st=%0d rty=%0d loss=%0d want prst=%b srst=%b rdy=%b flt=%b st=%0d rty=%0d loss=%0d",
                 $time, act_v[16], act_v[15], act_v[14], act_v[13], act_v[12:10],
                 act_v[9:8], act_v[7:0], exp_v[16], exp_v[15], exp_v[14],
                 exp_v[13], exp_v[12:10], exp_v[9:8], exp_v[7:0]);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0d want %0d", nm, $time, act, exp);
    end else begin
      $display("check %s t=%0t value %0d", nm, $time, act);
    end
  endtask

  task automatic wait_state(input int s, input int budget);
    int n;
    n = 0;
    while (int'(state_o) != s && n < budget) begin
      tick(1);
      n++;
    end
    chk("wait_state", int'(state_o), s);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    tick(1);
    cmp_en = 1'b1;
    tick(2);
    chk("rst_pll_reset", pll_reset_o, 1);
    chk("rst_sys_reset", sys_reset_o, 1);
    chk("rst_ready", ready_o, 0);
    chk("rst_state", state_o, 0);
    rst = 1'b0;

    // 1: normal bring-up, lock raised before edge 10
    tick(3);
    chk("t1_prst_e3", pll_reset_o, 1);
    tick(1);
    chk("t1_prst_e4", pll_reset_o, 0);
    chk("t1_wait_e4", state_o, 1);
    tick(5);
    pll_lock_i = 1'b1;
    tick(2);
    chk("t1_wait_e11", state_o, 1);
    tick(1);
    chk("t1_stable_e12", state_o, 2);
    tick(7);
    chk("t1_ready_e19", ready_o, 0);
    tick(1);
    chk("t1_ready_e20", ready_o, 1);
    chk("t1_sysrst_e20", sys_reset_o, 0);
    chk("t1_retry", retry_cnt_o, 0);

    // 4: lock loss in RUN
    pll_lock_i = 1'b0;
    tick(2);
    chk("t4_ready_d2", ready_o, 1);
    tick(1);
    chk("t4_ready_d3", ready_o, 0);
    chk("t4_sysrst_d3", sys_reset_o, 1);
    chk("t4_loss", lock_loss_cnt_o, 1);

    // 3: glitch in STABLE
    pll_lock_i = 1'b1;
    wait_state(2, 50);
    tick(4);
    pll_lock_i = 1'b0;
    tick(3);
    chk("t3_state", state_o, 0);
    chk("t3_retry", retry_cnt_o, 1);
    pll_lock_i = 1'b1;
    wait_state(3, 60);
    chk("t3_retry_run", retry_cnt_o, 0);

    // 5b: restart coincident with lock loss in RUN
    pll_lock_i = 1'b0;
    tick(2);
    restart_i = 1'b1;
    tick(1);
    restart_i = 1'b0;
    chk("t5b_state", state_o, 0);
    chk("t5b_loss", lock_loss_cnt_o, 2);

    // 4b: saturation after 256 further losses
    for (int i = 0; i < 256; i++) begin
      pll_lock_i = 1'b1;
      wait_state(3, 60);
      pll_lock_i = 1'b0;
      wait_state(0, 10);
    end
    chk("t4_loss_sat", lock_loss_cnt_o, 255);

    // 2: lock timeout, three 24-cycle attempts
    restart_i = 1'b1;
    tick(1);
    restart_i = 1'b0;
    tick(24);
    chk("t2_retry_24", retry_cnt_o, 1);
    chk("t2_state_24", state_o, 0);
    tick(24);
    chk("t2_retry_48", retry_cnt_o, 2);
    tick(23);
    chk("t2_fault_71", fault_o, 0);
    tick(1);
    chk("t2_fault_72", fault_o, 1);
    chk("t2_retry_72", retry_cnt_o, 3);
    chk("t2_state_72", state_o, 4);
    for (int i = 0; i < 100; i++) begin
      tick(1);
      chk("t2_hold", {30'd0, pll_reset_o, sys_reset_o}, 3);
    end

    // 5a: restart from FAULT
    restart_i = 1'b1;
    tick(1);
    restart_i = 1'b0;
    chk("t5a_fault", fault_o, 0);
    chk("t5a_retry", retry_cnt_o, 0);
    chk("t5a_state", state_o, 0);

    // 6: async reset between edges while in STABLE
    pll_lock_i = 1'b1;
    wait_state(2, 40);
    tick(2);
    #3;
    rst = 1'b1;
    #1;
    chk("t6_state", state_o, 0);
    chk("t6_pll_reset", pll_reset_o, 1);
    chk("t6_sys_reset", sys_reset_o, 1);
    chk("t6_ready", ready_o, 0);
    chk("t6_fault", fault_o, 0);
    chk("t6_retry", retry_cnt_o, 0);
    chk("t6_loss", lock_loss_cnt_o, 0);
    tick(2);
    rst = 1'b0;
    tick(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
